// File: rtl/prng_pkg.sv
// Shared constants for the PRNG: tap masks and default seeds per LFSR width,
// plus the run-mode encoding used by prng_core.
package prng_pkg;

    typedef enum logic {
        MODE_FREE   = 1'b0,
        MODE_DEMAND = 1'b1
    } prng_mode_e;

    // Tap masks use 0-based bit positions (1-based tap k sits at bit k-1)
    localparam logic [31:0] TAPS_8  = 32'h0000_00B8;
    localparam logic [31:0] TAPS_16 = 32'h0000_D008;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;

    localparam logic [15:0] DEF_SEED_D_16 = 16'hACE1;
    localparam logic [31:0] DEF_SEED_D_32 = 32'hACE1_2468;
    localparam logic [7:0]  DEF_SEED_C_8  = 8'h5A;
    localparam logic [15:0] DEF_SEED_C_16 = 16'h5A3C;

    function automatic logic [31:0] tap_mask(input int width);
        case (width)
            8:       return TAPS_8;
            16:      return TAPS_16;
            default: return TAPS_32;
        endcase
    endfunction

    function automatic logic [31:0] def_seed_d(input int data_w);
        return (data_w == 32) ? DEF_SEED_D_32 : {16'h0000, DEF_SEED_D_16};
    endfunction

    function automatic logic [31:0] def_seed_c(input int out_w);
        return (out_w == 16) ? {16'h0000, DEF_SEED_C_16} : {24'h000000, DEF_SEED_C_8};
    endfunction

endpackage

// File: rtl/prng_lfsr.sv
// Fibonacci LFSR, shift left with XOR feedback into bit 0; supports seed load
// and recovers from the all-zero lockup state by reloading its default.
module prng_lfsr #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = '1,
    parameter logic [WIDTH-1:0] DEF_SEED = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    output logic [WIDTH-1:0] q
);

    logic feedback;

    assign feedback = ^(q & TAPS);

    // Zero values, loaded or held, are never allowed to persist
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= DEF_SEED;
        end else if (load) begin
            q <= (load_val == '0) ? DEF_SEED : load_val;
        end else if (q == '0) begin
            q <= DEF_SEED;
        end else if (step) begin
            q <= {q[WIDTH-2:0], feedback};
        end
    end

endmodule

// File: rtl/prng_core.sv
// PRNG top: tick divider, two LFSRs combined into an OUT_W word, and a
// valid/ready output with free-run (overwriting) and on-demand modes.
module prng_core
    import prng_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OUT_W  = DATA_W / 2,
    parameter int DIV_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              mode,
    input  logic [DIV_W-1:0]  div_max,
    input  logic              seed_load,
    input  logic [DATA_W-1:0] seed,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun
);

    localparam logic [31:0]       D_TAPS_FULL = tap_mask(DATA_W);
    localparam logic [31:0]       C_TAPS_FULL = tap_mask(OUT_W);
    localparam logic [31:0]       D_SEED_FULL = def_seed_d(DATA_W);
    localparam logic [31:0]       C_SEED_FULL = def_seed_c(OUT_W);
    localparam logic [DATA_W-1:0] D_TAPS      = D_TAPS_FULL[DATA_W-1:0];
    localparam logic [OUT_W-1:0]  C_TAPS      = C_TAPS_FULL[OUT_W-1:0];
    localparam logic [DATA_W-1:0] D_SEED      = D_SEED_FULL[DATA_W-1:0];
    localparam logic [OUT_W-1:0]  C_SEED      = C_SEED_FULL[OUT_W-1:0];

    logic [DIV_W-1:0]  cnt;
    logic              tick;
    prng_mode_e        mode_q;
    logic              mode_change;
    logic              pending;
    logic              step;
    logic              transfer;
    logic [DATA_W-1:0] data_q;
    logic [OUT_W-1:0]  ctrl_q;
    logic [OUT_W-1:0]  word;

    prng_lfsr #(.WIDTH(DATA_W), .TAPS(D_TAPS), .DEF_SEED(D_SEED)) u_data_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (seed_load),
        .load_val (seed),
        .step     (step),
        .q        (data_q)
    );

    prng_lfsr #(.WIDTH(OUT_W), .TAPS(C_TAPS), .DEF_SEED(C_SEED)) u_ctrl_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (seed_load),
        .load_val (seed[DATA_W-1 -: OUT_W]),
        .step     (step),
        .q        (ctrl_q)
    );

    // The registered mode decides stepping, so a mode change lands one cycle later
    always_comb begin
        tick        = en && (cnt == div_max);
        mode_change = (prng_mode_e'(mode) != mode_q);
        transfer    = out_valid && out_ready;
        step        = 1'b0;
        if (mode_q == MODE_FREE) begin
            step = tick;
        end else begin
            step = en && (pending || tick) && (!out_valid || out_ready);
        end
        if (seed_load) begin
            step = 1'b0;
        end
        word = '0;
        for (int i = 0; i < OUT_W; i++) begin
            word[i] = ctrl_q[i] ? data_q[2*i+1] : data_q[2*i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (seed_load || !en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q  <= MODE_FREE;
            pending <= 1'b0;
        end else begin
            mode_q <= prng_mode_e'(mode);
            if (seed_load || mode_change || mode_q == MODE_FREE || step) begin
                pending <= 1'b0;
            end else if (tick) begin
                pending <= 1'b1;
            end
        end
    end

    // A step while a word is still unconsumed only happens in free-run mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (seed_load) begin
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (step) begin
            out_data  <= word;
            out_valid <= 1'b1;
            if (out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end else if (transfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/prng_core.md
PRNG_CORE -- requirements
Module: prng_core

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, setting the data LFSR width; legal values are 16 and 32.
REQ-002 The block SHALL have parameter OUT_W, default DATA_W/2, setting the output word and control LFSR width; it is fixed at DATA_W/2.
REQ-003 The block SHALL have parameter DIV_W, default 24, setting the tick divider width.
REQ-004 clk  in  1  single clock; all state SHALL be on posedge clk.
REQ-005 reset  in  1  reset, asynchronous and active-high.
REQ-006 en  in  1  synchronous run enable.
REQ-007 mode  in  1  0 = free-run, 1 = on-demand.
REQ-008 div_max  in  DIV_W  tick period minus 1.
REQ-009 seed_load  in  1  one-cycle seed strobe.
REQ-010 seed  in  DATA_W  seed value.
REQ-011 out_data  out  OUT_W  random word.
REQ-012 out_valid  out  1  out_data holds an unconsumed word.
REQ-013 out_ready  in  1  consumer accepts the word.
REQ-014 overrun  out  1  sticky flag: an unconsumed word was overwritten.

Function
REQ-015 Divider: with en=1 the counter SHALL count 0..div_max and then wrap to 0; tick SHALL be 1 for one cycle when counter==div_max; div_max=0 SHALL give a tick on every enabled cycle.
REQ-016 With en=0 the divider SHALL hold at 0, no tick SHALL occur, and the LFSRs SHALL hold; the output handshake SHALL keep operating.
REQ-017 Data LFSR: Fibonacci, XOR feedback, shift left, feedback into bit 0; taps SHALL be 16:{16,15,13,4} and 32:{32,22,2,1} (1-based).
REQ-018 Control LFSR: same structure with OUT_W width; taps SHALL be 8:{8,6,5,4} and 16:{16,15,13,4}.
REQ-019 Combine: word bit i SHALL be data[2i+1] when ctrl[i]=1, otherwise data[2i], computed from pre-step register values.
REQ-020 Step: on a step edge both LFSRs SHALL advance one position and out_data SHALL load the combined word; out_valid SHALL be 1 on the following cycle, giving 1-cycle latency from the step.
REQ-021 Mode 0: a step SHALL occur on every tick; if out_valid=1 and out_ready=0 on that tick, the word SHALL be overwritten and overrun SHALL be set.
REQ-022 Mode 1: a tick SHALL set a pending flag; a step SHALL occur when the pending flag (or the tick) is set and (out_valid=0 or out_ready=1); multiple ticks SHALL collapse into one pending step; overrun SHALL never set.
REQ-023 Handshake: a transfer SHALL occur when out_valid and out_ready are both 1.
REQ-024 On a transfer without a step, out_valid SHALL be 0 on the next cycle.
REQ-025 On a transfer with a step in the same cycle, out_valid SHALL stay 1 and out_data SHALL carry the new word.
REQ-026 While out_valid=1 and out_ready=0 in mode 1, out_data SHALL be stable.
REQ-027 seed_load: the data LFSR SHALL load seed, and the control LFSR SHALL load seed[DATA_W-1 -: OUT_W].
REQ-028 seed_load: any all-zero value SHALL be replaced by the package default for that LFSR.
REQ-029 seed_load SHALL clear out_valid, overrun, pending and the divider counter.
REQ-030 seed_load SHALL take priority over a tick or step in the same cycle.
REQ-031 Lockup guard: if either LFSR holds all zeros, its next value SHALL be its package default.
REQ-032 A mode change SHALL take effect on the next cycle and SHALL clear pending.

Reset
REQ-033 On reset the data LFSR SHALL be DEF_SEED_D (16'hACE1 / 32'hACE1_2468) and the control LFSR SHALL be DEF_SEED_C (8'h5A / 16'h5A3C).
REQ-034 On reset out_data SHALL be 0, out_valid 0, overrun 0, pending 0 and the counter 0.
REQ-035 Reset asserted mid-operation SHALL take effect immediately, without waiting for a clock edge.

Structure
REQ-036 Package prng_pkg SHALL hold the tap masks per width, DEF_SEED_D/DEF_SEED_C per width, and a function returning the tap mask for a given width.
REQ-037 One sub-module, prng_lfsr (parametrised width, taps, default seed, load and step), SHALL be instantiated twice.
REQ-038 The divider, combine logic and handshake SHALL stay in prng_core.

Verification
REQ-039 Reset test: assert reset -> out_valid=0, out_data=0, overrun=0; the first step after reset with default seeds yields the combine of 16'hACE1/8'h5A.
REQ-040 Seed test: DATA_W=16, seed_load seed=16'hFF00, mode=1, div_max=0, out_ready=1 -> out_data=8'hF0 and out_valid=1 one cycle after the first step.
REQ-041 Divider test: mode=0, div_max=3, out_ready=1 -> a step on exactly every 4th enabled cycle; en=0 for 10 cycles -> no steps and LFSRs frozen.
REQ-042 Backpressure test: mode=1, div_max=0, out_ready=0 for 20 cycles -> one word, out_data stable, overrun=0; on out_ready=1 -> back-to-back words with out_valid held at 1.
REQ-043 Overrun test: mode=0, div_max=0, out_ready=0 -> overrun=1 after the second step; a seed_load pulse -> overrun=0 and out_valid=0.
REQ-044 Zero-seed and period test: seed_load seed=0 -> data LFSR=16'hACE1; 65535 steps -> data LFSR returns to its seed, and reset mid-run clears everything asynchronously.
